// File: rtl/key_pkg.sv
// Shared definitions for the keyfilter family: click FSM state encoding and
// millisecond-to-cycle conversion.
package key_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ONE  = 2'd1,
        S_TWO  = 2'd2
    } key_state_e;

    function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned ms);
        return (freq_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/key_click_decoder_if.sv
// Click-decoder bus: debounced key pulse in, classified clicks and adjust value out.
interface key_click_decoder_if #(
    parameter int unsigned VAL_W = 8
);
    logic             key_pulse;
    logic             single_click;
    logic             double_click;
    logic             triple_click;
    logic [VAL_W-1:0] value;
    logic             value_changed;

    modport master (
        output key_pulse,
        input  single_click, double_click, triple_click, value, value_changed
    );

    modport slave (
        input  key_pulse,
        output single_click, double_click, triple_click, value, value_changed
    );
endinterface

// File: rtl/click_window_timer.sv
// Inter-click window counter: cleared on demand, counts while enabled, and
// holds at WIN_CYC-1 with timeout asserted.
module click_window_timer #(
    parameter int unsigned WIN_CYC = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);
    localparam int unsigned CNT_W = $clog2(WIN_CYC) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (cnt_q == CNT_W'(WIN_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !timeout) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/key_click_decoder.sv
// Classifies bursts of key pulses as single/double/triple clicks and applies
// +STEP / -STEP / reload-to-VAL_INIT to a bounded adjust register.
module key_click_decoder
    import key_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 65_000_000,
    parameter int unsigned WINDOW_MS   = 300,
    parameter int unsigned VAL_W       = 8,
    parameter int unsigned VAL_MIN     = 0,
    parameter int unsigned VAL_MAX     = 255,
    parameter int unsigned VAL_INIT    = 128,
    parameter int unsigned STEP        = 1,
    parameter int unsigned WRAP        = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    key_click_decoder_if.slave   bus
);
    localparam int unsigned WIN_CYC = ms_to_cycles(CLK_FREQ_HZ, WINDOW_MS);
    localparam int unsigned EXT_W   = VAL_W + 1;

    key_state_e       state_q, state_d;
    logic             single_q, single_d;
    logic             double_q, double_d;
    logic             triple_q, triple_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic             changed_q, changed_d;
    logic             timeout;

    click_window_timer #(
        .WIN_CYC (WIN_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (bus.key_pulse || (state_q == S_IDLE)),
        .enable  (state_q != S_IDLE),
        .timeout (timeout)
    );

    // A pulse always beats a simultaneous timeout: it is the next click of the burst.
    always_comb begin
        state_d  = state_q;
        single_d = 1'b0;
        double_d = 1'b0;
        triple_d = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.key_pulse) state_d = S_ONE;
            S_ONE: begin
                if (bus.key_pulse) begin
                    state_d = S_TWO;
                end else if (timeout) begin
                    state_d  = S_IDLE;
                    single_d = 1'b1;
                end
            end
            S_TWO: begin
                if (bus.key_pulse) begin
                    state_d  = S_IDLE;
                    triple_d = 1'b1;
                end else if (timeout) begin
                    state_d  = S_IDLE;
                    double_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Extended-width arithmetic so neither sum nor difference can overflow.
    logic [EXT_W-1:0] val_ext, sum_ext, diff_ext;
    logic [VAL_W-1:0] inc_val, dec_val;

    always_comb begin
        val_ext  = {1'b0, value_q};
        sum_ext  = val_ext + EXT_W'(STEP);
        diff_ext = val_ext - EXT_W'(STEP);
        if (sum_ext > EXT_W'(VAL_MAX)) begin
            inc_val = (WRAP != 0) ? VAL_W'(VAL_MIN) : VAL_W'(VAL_MAX);
        end else begin
            inc_val = sum_ext[VAL_W-1:0];
        end
        if (val_ext < EXT_W'(VAL_MIN) + EXT_W'(STEP)) begin
            dec_val = (WRAP != 0) ? VAL_W'(VAL_MAX) : VAL_W'(VAL_MIN);
        end else begin
            dec_val = diff_ext[VAL_W-1:0];
        end
        value_d = value_q;
        if (single_d) begin
            value_d = inc_val;
        end else if (double_d) begin
            value_d = dec_val;
        end else if (triple_d) begin
            value_d = VAL_W'(VAL_INIT);
        end
        changed_d = (value_d != value_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            triple_q  <= 1'b0;
            value_q   <= VAL_W'(VAL_INIT);
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            single_q  <= single_d;
            double_q  <= double_d;
            triple_q  <= triple_d;
            value_q   <= value_d;
            changed_q <= changed_d;
        end
    end

    assign bus.single_click  = single_q;
    assign bus.double_click  = double_q;
    assign bus.triple_click  = triple_q;
    assign bus.value         = value_q;
    assign bus.value_changed = changed_q;
endmodule

// File: tb/tb_key_click_decoder.sv
// Scoreboard bench: three decoder instances (default, saturating 0..130, wrapping 0..130)
// driven with directed click bursts; a negedge monitor matches outputs against queued events.
module tb_key_click_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_s, rst_w;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int         cyc;
        int         kind;   // 1 single, 2 double, 3 triple
        logic [7:0] val;
        logic       chg;
    } exp_t;

    exp_t q_a[$];
    exp_t q_s[$];
    exp_t q_w[$];

    key_click_decoder_if #(.VAL_W(8)) bus_a ();
    key_click_decoder_if #(.VAL_W(8)) bus_s ();
    key_click_decoder_if #(.VAL_W(8)) bus_w ();

    key_click_decoder #(
        .CLK_FREQ_HZ (1000), .WINDOW_MS (10), .VAL_W (8), .VAL_MIN (0),
        .VAL_MAX (255), .VAL_INIT (128), .STEP (1), .WRAP (0)
    ) dut_a (.clk (clk), .rst (rst_a), .bus (bus_a));

    key_click_decoder #(
        .CLK_FREQ_HZ (1000), .WINDOW_MS (10), .VAL_W (8), .VAL_MIN (0),
        .VAL_MAX (130), .VAL_INIT (128), .STEP (1), .WRAP (0)
    ) dut_s (.clk (clk), .rst (rst_s), .bus (bus_s));

    key_click_decoder #(
        .CLK_FREQ_HZ (1000), .WINDOW_MS (10), .VAL_W (8), .VAL_MIN (0),
        .VAL_MAX (130), .VAL_INIT (128), .STEP (1), .WRAP (1)
    ) dut_w (.clk (clk), .rst (rst_w), .bus (bus_w));

    function automatic void push_exp(input int sel, input exp_t e);
        case (sel)
            0:       q_a.push_back(e);
            1:       q_s.push_back(e);
            default: q_w.push_back(e);
        endcase
    endfunction

    function automatic bit pop_exp(input int sel, output exp_t e);
        bit ok;
        ok = 1'b0;
        e  = '{cyc: 0, kind: 0, val: 8'd0, chg: 1'b0};
        case (sel)
            0:       if (q_a.size() > 0) begin e = q_a.pop_front(); ok = 1'b1; end
            1:       if (q_s.size() > 0) begin e = q_s.pop_front(); ok = 1'b1; end
            default: if (q_w.size() > 0) begin e = q_w.pop_front(); ok = 1'b1; end
        endcase
        return ok;
    endfunction

    function automatic int q_size(input int sel);
        case (sel)
            0:       return q_a.size();
            1:       return q_s.size();
            default: return q_w.size();
        endcase
    endfunction

    // Monitor: any click or value_changed pulse must match the head of that DUT's queue.
    always @(negedge clk) begin
        logic       sc, dc, tc, vc;
        logic [7:0] v;
        int         kind;
        exp_t       e;
        if (mon_en) begin
            for (int s = 0; s < 3; s++) begin
                case (s)
                    0: begin sc = bus_a.single_click; dc = bus_a.double_click;
                             tc = bus_a.triple_click; vc = bus_a.value_changed; v = bus_a.value; end
                    1: begin sc = bus_s.single_click; dc = bus_s.double_click;
                             tc = bus_s.triple_click; vc = bus_s.value_changed; v = bus_s.value; end
                    default: begin sc = bus_w.single_click; dc = bus_w.double_click;
                             tc = bus_w.triple_click; vc = bus_w.value_changed; v = bus_w.value; end
                endcase
                if (sc || dc || tc || vc) begin
                    kind = tc ? 3 : (dc ? 2 : (sc ? 1 : 0));
                    checks++;
                    if (int'(sc) + int'(dc) + int'(tc) > 1) begin
                        failures++;
                        $display("FAIL dut%0d onehot: got s=%0b d=%0b t=%0b, want at most one",
                                 s, sc, dc, tc);
                    end
                    checks++;
                    if (!pop_exp(s, e)) begin
                        failures++;
                        $display("FAIL dut%0d unexpected event: got kind=%0d val=%0d chg=%0b at cyc=%0d, want none",
                                 s, kind, v, vc, cyc);
                    end else if (kind != e.kind || cyc != e.cyc || v != e.val || vc != e.chg) begin
                        failures++;
                        $display("FAIL dut%0d event: got kind=%0d cyc=%0d val=%0d chg=%0b, want kind=%0d cyc=%0d val=%0d chg=%0b",
                                 s, kind, cyc, v, vc, e.kind, e.cyc, e.val, e.chg);
                    end
                end
            end
        end
    end

    task automatic set_in(input int sel, input logic k, input logic r);
        case (sel)
            0:       begin bus_a.key_pulse = k; rst_a = r; end
            1:       begin bus_s.key_pulse = k; rst_s = r; end
            default: begin bus_w.key_pulse = k; rst_w = r; end
        endcase
    endtask

    // Drives pat[i] as key_pulse in burst cycle i; expected event lands in burst cycle ecyc.
    task automatic burst(input int sel, input logic [31:0] pat, input int rst_at,
                         input int ecyc, input int kind, input logic [7:0] val, input logic chg);
        int base;
        int len;
        @(posedge clk);
        #1;
        base = cyc;
        len  = (kind != 0) ? ecyc + 2 : 20;
        if (kind != 0) push_exp(sel, '{cyc: base + ecyc, kind: kind, val: val, chg: chg});
        for (int i = 0; i < len; i++) begin
            set_in(sel, pat[i], (i == rst_at));
            @(posedge clk);
            #1;
        end
        set_in(sel, 1'b0, 1'b0);
    endtask

    task automatic check_idle(input int sel, input string name, input logic [7:0] want);
        logic [7:0] v;
        logic       any;
        case (sel)
            0:       begin v = bus_a.value; any = bus_a.single_click | bus_a.double_click |
                                                  bus_a.triple_click | bus_a.value_changed; end
            1:       begin v = bus_s.value; any = bus_s.single_click | bus_s.double_click |
                                                  bus_s.triple_click | bus_s.value_changed; end
            default: begin v = bus_w.value; any = bus_w.single_click | bus_w.double_click |
                                                  bus_w.triple_click | bus_w.value_changed; end
        endcase
        checks++;
        if (v !== want || any !== 1'b0) begin
            failures++;
            $display("FAIL %s: got value=%0d pulses=%0b, want value=%0d pulses=0", name, v, any, want);
        end
    endtask

    initial begin
        bus_a.key_pulse = 1'b0;
        bus_s.key_pulse = 1'b0;
        bus_w.key_pulse = 1'b0;
        rst_a = 1'b1;
        rst_s = 1'b1;
        rst_w = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_s = 1'b0;
        rst_w = 1'b0;
        check_idle(0, "reset_a", 8'd128);
        check_idle(1, "reset_s", 8'd128);
        check_idle(2, "reset_w", 8'd128);
        mon_en = 1'b1;

        // Default instance
        burst(0, 32'h1,   -1, 11, 1, 8'd129, 1'b1);  // single
        burst(0, 32'h21,  -1, 16, 2, 8'd128, 1'b1);  // double
        burst(0, 32'h1,   -1, 11, 1, 8'd129, 1'b1);
        burst(0, 32'h1,   -1, 11, 1, 8'd130, 1'b1);
        burst(0, 32'h1,   -1, 11, 1, 8'd131, 1'b1);
        burst(0, 32'h111, -1,  9, 3, 8'd128, 1'b1);  // triple reload
        burst(0, 32'h401, -1, 21, 2, 8'd127, 1'b1);  // 2nd click on timeout cycle
        burst(0, 32'h1,    5,  0, 0, 8'd0,   1'b0);  // reset mid-burst
        check_idle(0, "after_midburst_reset", 8'd128);
        burst(0, 32'h1,   -1, 11, 1, 8'd129, 1'b1);
        burst(0, 32'h21,  -1, 16, 2, 8'd128, 1'b1);
        burst(0, 32'h111, -1,  9, 3, 8'd128, 1'b0);  // triple at VAL_INIT: no change

        // Saturating 0..130
        burst(1, 32'h1,  -1, 11, 1, 8'd129, 1'b1);
        burst(1, 32'h1,  -1, 11, 1, 8'd130, 1'b1);
        burst(1, 32'h1,  -1, 11, 1, 8'd130, 1'b0);
        burst(1, 32'h1,  -1, 11, 1, 8'd130, 1'b0);
        burst(1, 32'h21, -1, 16, 2, 8'd129, 1'b1);

        // Wrapping 0..130
        burst(2, 32'h1,  -1, 11, 1, 8'd129, 1'b1);
        burst(2, 32'h1,  -1, 11, 1, 8'd130, 1'b1);
        burst(2, 32'h1,  -1, 11, 1, 8'd0,   1'b1);
        burst(2, 32'h21, -1, 16, 2, 8'd130, 1'b1);

        repeat (5) @(posedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (q_size(s) != 0) begin
                failures++;
                $display("FAIL dut%0d missing events: got %0d unmatched, want 0", s, q_size(s));
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
